vrased_log_reader: RTL and testbench
====================================

Name: vrased_log_reader

Overview:
- Read-side drain engine for the VRASED violation log RAM; the logger is the writer.
- On a start pulse it snapshots the logger's entry count and reads entries 0..N-1 through the RAM read port (re/rd_addr/rd_data).
- Each 38-bit record is presented on a valid/ready stream toward the attestation/report path, with a last marker.
- Sits beside the logger/RAM pair inside the vrased top; it is the only RAM reader.

Parameters:
- DATA_W, 38, log record width; matches RAM rd_data.
- ADDR_W, 16, RAM address width.
- DEPTH, 256, number of physical log entries; count is clamped to this.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle drain request.
- wr_count  input  16  number of entries written by the logger since the last clear.
- re  output  1  RAM read enable.
- rd_addr  output  ADDR_W  RAM read address.
- rd_data  input  DATA_W  RAM read data, valid one cycle after re.
- out_valid  output  1  record valid.
- out_ready  input  1  consumer accepts the record.
- out_data  output  DATA_W  record.
- out_last  output  1  marks the final record of the drain.
- busy  output  1  drain in progress.
- overflow  output  1  sticky flag: snapshot count exceeded DEPTH.
- clr_ram  output  1  RAM clear pulse (present only with the optional feature; tied 0 otherwise).

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, idx=0, total=0.
- FSM states: IDLE, RD, WAIT, HOLD, DONE.
- IDLE:
  - start=1 snapshots total = min(wr_count, DEPTH) and sets overflow if wr_count > DEPTH.
  - If total=0, go to DONE (no record emitted). Otherwise idx=0 and go to RD.
- RD: re=1, rd_addr=idx (zero-extended). Next state WAIT.
- WAIT:
  - re=0; out_data <= rd_data registered at the end of this cycle.
  - out_last <= (idx == total-1). Next state HOLD.
- HOLD:
  - out_valid=1; out_data and out_last are held stable until the handshake (out_valid & out_ready).
  - On handshake: out_valid drops the next cycle. If out_last, go to DONE; else idx+1 and go to RD.
- DONE: busy=0 and return to IDLE in one cycle.
- busy=1 in RD, WAIT and HOLD.
- Latency: start accepted at cycle T, re at T+1, first out_valid at T+3. With out_ready held at 1, one record is emitted per 3 cycles.
- start while busy is ignored and does not restart the drain.
- wr_count changes during a drain are ignored; only the snapshot is used.
- overflow is sticky until reset_n or the next accepted start, which recomputes it.
- idx arithmetic is 16-bit; total never exceeds DEPTH, so idx does not wrap.
- out_ready before out_valid is ignored.
- Reset mid-drain: the record is discarded, all outputs return to 0, the FSM goes to IDLE, and no clr_ram pulse is issued.

Optional Feature:
- Macro: VRASED_LOG_AUTO_CLEAR_EN.
- Enabled:
  - On the handshake of the out_last record, clr_ram pulses high for exactly one cycle, in the DONE cycle.
  - An empty drain (total=0) also pulses clr_ram in DONE.
  - Reset mid-drain never pulses clr_ram.
- Disabled: clr_ram is tied 0 and the RAM is cleared only externally.

Decomposition:
- Shared package vrased_log_pkg holds:
  - LOG_DATA_W=38, LOG_ADDR_W=16, LOG_DEPTH=256.
  - The FSM state enum (IDLE/RD/WAIT/HOLD/DONE).
  - Record field offsets, shared with the logger.
- Sub-module: vrased_log_out_reg, the holding register for out_data/out_last/out_valid with the stall/handshake logic. Everything else stays in the top FSM.

Test Plan:
- wr_count=3, records 0x0000000001/0x0000000002/0x0000000003 preloaded, out_ready=1, start at T -> re at T+1, T+4, T+7; three handshakes with data 1, 2, 3; out_last only on the third; busy falls after DONE.
- wr_count=0, start -> no re, no out_valid, busy=0 within 2 cycles; with VRASED_LOG_AUTO_CLEAR_EN, one clr_ram pulse.
- wr_count=300, DEPTH=256 -> overflow=1; exactly 256 records; last rd_addr=0x00FF.
- wr_count=2, out_ready held 0 for 10 cycles in HOLD -> out_data and out_valid stable, no new re; release -> record accepted, drain continues.
- Drain of 4 entries, second start pulse mid-drain and wr_count changed to 9 -> ignored, still 4 records.
- reset_n=0 during HOLD of entry 1 of 4 -> next cycle all outputs 0, IDLE, no clr_ram; a new start redrains from idx 0.

Source files
------------

// File: rtl/vrased_log_pkg.sv
// Shared definitions for the VRASED violation log (logger writer, reader drain engine).
package vrased_log_pkg;

  localparam int unsigned LOG_DATA_W = 38;
  localparam int unsigned LOG_ADDR_W = 16;
  localparam int unsigned LOG_DEPTH  = 256;

  // Record layout, shared with the logger: {code[5:0], addr[15:0], pc[15:0]}
  localparam int unsigned LOG_PC_LSB    = 0;
  localparam int unsigned LOG_PC_W      = 16;
  localparam int unsigned LOG_ADDR_LSB  = 16;
  localparam int unsigned LOG_ADDR_FW   = 16;
  localparam int unsigned LOG_CODE_LSB  = 32;
  localparam int unsigned LOG_CODE_W    = 6;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    HOLD,
    DONE
  } log_state_t;

  function automatic logic [15:0] clamp_count(input logic [15:0] cnt, input logic [15:0] depth);
    return (cnt > depth) ? depth : cnt;
  endfunction

endpackage

// File: rtl/vrased_log_out_reg.sv
// Output holding register for the drain stream: loads one record, holds it until accepted.
module vrased_log_out_reg #(
  parameter int unsigned DATA_W = 38
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              fire
);

  assign fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vrased_log_reader.sv
// Drains the VRASED violation log RAM onto a valid/ready stream.
// Optional RAM auto-clear after a drain: define VRASED_LOG_AUTO_CLEAR_EN.
module vrased_log_reader
  import vrased_log_pkg::*;
#(
  parameter int unsigned DATA_W = LOG_DATA_W,
  parameter int unsigned ADDR_W = LOG_ADDR_W,
  parameter int unsigned DEPTH  = LOG_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       wr_count,
  output logic              re,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              overflow,
  output logic              clr_ram
);

`ifdef VRASED_LOG_AUTO_CLEAR_EN
  localparam bit AUTO_CLEAR = 1'b1;
`else
  localparam bit AUTO_CLEAR = 1'b0;
`endif

  localparam logic [15:0] DEPTH_C = 16'(DEPTH);

  log_state_t  state;
  logic [15:0] idx;
  logic [15:0] total;
  logic [15:0] snap;
  logic        load;
  logic        last_next;
  logic        fire;

  assign snap      = clamp_count(wr_count, DEPTH_C);
  assign load      = (state == WAIT);
  assign last_next = (idx == total - 16'd1);

  vrased_log_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (rd_data),
    .load_last (last_next),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .fire      (fire)
  );

  // re/busy/clr_ram are set on the transition into a state so they are registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      total    <= '0;
      re       <= 1'b0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      clr_ram  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_ram <= 1'b0;
          if (start) begin
            total    <= snap;
            overflow <= (wr_count > DEPTH_C);
            if (snap == '0) begin
              clr_ram <= AUTO_CLEAR;
              state   <= DONE;
            end else begin
              idx     <= '0;
              re      <= 1'b1;
              rd_addr <= '0;
              busy    <= 1'b1;
              state   <= RD;
            end
          end
        end
        RD: begin
          re    <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          state <= HOLD;
        end
        HOLD: begin
          if (fire) begin
            if (out_last) begin
              busy    <= 1'b0;
              clr_ram <= AUTO_CLEAR;
              state   <= DONE;
            end else begin
              idx     <= idx + 16'd1;
              re      <= 1'b1;
              rd_addr <= ADDR_W'(idx + 16'd1);
              state   <= RD;
            end
          end
        end
        DONE: begin
          clr_ram <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vrased_log_reader.sv
// Directed bench for vrased_log_reader with a one-cycle-latency RAM model.
module tb_vrased_log_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] wr_count;
  logic        re;
  logic [15:0] rd_addr;
  logic [37:0] rd_data = '0;
  logic        out_valid;
  logic        out_ready;
  logic [37:0] out_data;
  logic        out_last;
  logic        busy;
  logic        overflow;
  logic        clr_ram;

`ifdef VRASED_LOG_AUTO_CLEAR_EN
  localparam int EXP_CLR = 1;
`else
  localparam int EXP_CLR = 0;
`endif

  vrased_log_reader #(.DATA_W(38), .ADDR_W(16), .DEPTH(256)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .wr_count  (wr_count),
    .re        (re),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .overflow  (overflow),
    .clr_ram   (clr_ram)
  );

  always #5 clk = ~clk;

  logic [37:0] mem [256];

  function automatic logic [37:0] exp_rec(input int i);
    logic [37:0] r;
    r = 38'(i + 1);
    if (i >= 8) r = r | 38'h2A_0000_0000;
    return r;
  endfunction

  always @(posedge clk) if (re) rd_data <= mem[rd_addr[7:0]];

  int n_assert = 0;
  int n_fail   = 0;
  int nrec, nlast, clr_cnt, first_valid, last_addr, done_cyc;
  int re_cyc[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_drain(input logic [15:0] wc, input int exp_n, input int poke);
    bit done;
    nrec = 0; nlast = 0; clr_cnt = 0; first_valid = -1; last_addr = -1; done_cyc = -1;
    re_cyc.delete();
    out_ready = 1'b1;
    @(negedge clk); wr_count = wc; start = 1'b1;
    @(negedge clk); start = 1'b0;
    done = 1'b0;
    for (int c = 1; c <= 3 * exp_n + 20 && !done; c++) begin
      if (c == poke) begin
        start = 1'b1;
        wr_count = 16'd9;
      end else begin
        start = 1'b0;
      end
      if (re) begin
        re_cyc.push_back(c);
        last_addr = int'(rd_addr);
      end
      if (out_valid && first_valid < 0) first_valid = c;
      if (out_valid && out_ready) begin
        check("rec_data", 64'(out_data), 64'(exp_rec(nrec)));
        check("rec_last", 64'(out_last), 64'(nrec == exp_n - 1));
        if (out_last) nlast++;
        nrec++;
      end
      if (clr_ram) clr_cnt++;
      if (!busy && c > 0) begin
        done = 1'b1;
        done_cyc = c;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("drain_busy_end", 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [15:0] wc;
    int          exp_n;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[7];
  logic [37:0] held;
  int bad;

  initial begin
    vecs[0] = '{16'd3,   3,   1'b0};
    vecs[1] = '{16'd0,   0,   1'b0};
    vecs[2] = '{16'd1,   1,   1'b0};
    vecs[3] = '{16'd256, 256, 1'b0};
    vecs[4] = '{16'd257, 256, 1'b1};
    vecs[5] = '{16'd300, 256, 1'b1};
    vecs[6] = '{16'd2,   2,   1'b0};

    for (int i = 0; i < 256; i++) mem[i] = exp_rec(i);

    reset_n = 1'b0; start = 1'b0; wr_count = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({re, rd_addr, out_valid, out_data, out_last, busy, overflow, clr_ram}), 64'd0);
    reset_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_drain(vecs[v].wc, vecs[v].exp_n, -1);
      check("vec_nrec", 64'(nrec), 64'(vecs[v].exp_n));
      check("vec_nre", 64'(re_cyc.size()), 64'(vecs[v].exp_n));
      check("vec_nlast", 64'(nlast), 64'(vecs[v].exp_n > 0));
      check("vec_overflow", 64'(overflow), 64'(vecs[v].exp_ovf));
      @(negedge clk);
      if (clr_ram) clr_cnt++;
      check("vec_clr", 64'(clr_cnt), 64'(EXP_CLR));
      if (vecs[v].exp_n > 0) check("vec_last_addr", 64'(last_addr), 64'(vecs[v].exp_n - 1));
    end

    // Latency and throughput of a 3-entry drain
    run_drain(16'd3, 3, -1);
    check("lat_re0", 64'(re_cyc[0]), 64'd1);
    check("lat_re1", 64'(re_cyc[1]), 64'd4);
    check("lat_re2", 64'(re_cyc[2]), 64'd7);
    check("lat_valid", 64'(first_valid), 64'd3);
    check("lat_done", 64'(done_cyc), 64'd10);

    // Empty drain finishes immediately
    run_drain(16'd0, 0, -1);
    check("empty_done", 64'(done_cyc), 64'd1);
    check("empty_novalid", 64'(first_valid < 0), 64'd1);

    // Overflow is sticky until the next accepted start
    run_drain(16'd300, 256, -1);
    check("ovf_last_addr", 64'(last_addr), 64'h00FF);
    repeat (5) @(negedge clk);
    check("ovf_sticky", 64'(overflow), 64'd1);
    run_drain(16'd3, 3, -1);
    check("ovf_recomputed", 64'(overflow), 64'd0);

    // Stall in HOLD
    out_ready = 1'b0;
    @(negedge clk); wr_count = 16'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    check("stall_valid", 64'(out_valid), 64'd1);
    held = out_data;
    check("stall_data", 64'(held), 64'(exp_rec(0)));
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!out_valid || out_data !== held || re) bad++;
    end
    check("stall_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_resume_re", 64'({re, rd_addr, out_valid}), 64'({1'b1, 16'd1, 1'b0}));
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    check("stall_rec1", 64'({out_valid, out_last, out_data}), 64'({1'b1, 1'b1, exp_rec(1)}));
    for (int k = 0; k < 10 && busy; k++) @(negedge clk);
    check("stall_busy_end", 64'(busy), 64'd0);

    // Second start and wr_count change mid-drain are ignored
    run_drain(16'd4, 4, 5);
    check("restart_nrec", 64'(nrec), 64'd4);
    check("restart_nre", 64'(re_cyc.size()), 64'd4);
    check("restart_ovf", 64'(overflow), 64'd0);

    // Reset during HOLD of entry 1
    out_ready = 1'b0;
    @(negedge clk); wr_count = 16'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
    check("rst_hold_entry1", 64'({out_valid, rd_addr, out_data}), 64'({1'b1, 16'd1, exp_rec(1)}));
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_outputs_mid", 64'({re, rd_addr, out_valid, out_data, out_last, busy, overflow, clr_ram}), 64'd0);
    reset_n = 1'b1;
    clr_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (clr_ram || busy) clr_cnt++;
    end
    check("rst_no_clr_idle", 64'(clr_cnt), 64'd0);
    run_drain(16'd4, 4, -1);
    check("redrain_nrec", 64'(nrec), 64'd4);
    check("redrain_last_addr", 64'(last_addr), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
